// File: rtl/quad_decoder.sv
// -----------------------------------------------------------------------------
// quad_decoder
// Quadrature encoder decoder. Each channel is synchronized and can optionally
// be glitch-filtered. The decoded state S = {A,B} is compared with the previous
// state to produce a step pulse, a direction flag, a wrapping position count
// and a sticky error flag for illegal double-bit transitions.
//
// Optional feature macro: QUAD_GLITCH_FILTER_EN
//   defined   -> each synchronized channel must hold a new value for
//                FILTER_LEN consecutive samples before it enters S
//   undefined -> synchronizer outputs feed S directly (FILTER_LEN unused)
//
// Pipeline (filter excluded): SYNC_STAGES sync flops -> state stage -> outputs.
// A pin edge captured at clk edge n is reflected on the outputs after edge
// n+SYNC_STAGES+1.
// -----------------------------------------------------------------------------
module quad_decoder #(
    parameter int COUNT_W     = 32,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               chA,
    input  logic               chB,
    input  logic               err_clr,
    output logic               step,
    output logic               upDown,
    output logic [COUNT_W-1:0] count,
    output logic               err
);

    // Elaboration-time parameter range checks.
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_sync_range_check
        $error("quad_decoder: SYNC_STAGES must be in the range 2..4");
    end
    if (FILTER_LEN < 1) begin : g_filter_len_check
        $error("quad_decoder: FILTER_LEN must be at least 1");
    end

    // Map a Gray-coded AB state onto its position in the up sequence
    // 00 -> 10 -> 11 -> 01, so a forward step is +1 modulo 4.
    function automatic logic [1:0] ab_to_phase(input logic [1:0] ab);
        logic [1:0] ph;
        case (ab)
            2'b00:   ph = 2'd0;
            2'b10:   ph = 2'd1;
            2'b11:   ph = 2'd2;
            2'b01:   ph = 2'd3;
            default: ph = 2'd0;
        endcase
        return ph;
    endfunction

    // ------------------------------------------------------------------
    // Input synchronizers. A valid bit travels alongside the data so the
    // decoder only primes once real pin samples have reached the state stage.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] a_sync_r;
    logic [SYNC_STAGES-1:0] b_sync_r;
    logic [SYNC_STAGES-1:0] vld_sync_r;
    logic [1:0]             sync_ab_s;
    logic                   sync_vld_s;

    // Shift the asynchronous pins through the synchronizer chains.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_sync_r   <= '0;
            b_sync_r   <= '0;
            vld_sync_r <= '0;
        end else begin
            a_sync_r   <= {a_sync_r[SYNC_STAGES-2:0], chA};
            b_sync_r   <= {b_sync_r[SYNC_STAGES-2:0], chB};
            vld_sync_r <= {vld_sync_r[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign sync_ab_s  = {a_sync_r[SYNC_STAGES-1], b_sync_r[SYNC_STAGES-1]};
    assign sync_vld_s = vld_sync_r[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Optional glitch filter
    // ------------------------------------------------------------------
    logic [1:0] filt_ab_s;
    logic       filt_vld_s;

`ifdef QUAD_GLITCH_FILTER_EN
    localparam int FCNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;

    logic [1:0]        filt_ab_r;
    logic              filt_vld_r;
    logic [FCNT_W-1:0] filt_cnt_r [2];

    // Accept a channel change only after FILTER_LEN consecutive differing
    // samples; the first valid sample after reset is loaded directly.
    always_ff @(posedge clk) begin
        if (reset) begin
            filt_ab_r     <= 2'b00;
            filt_vld_r    <= 1'b0;
            filt_cnt_r[0] <= '0;
            filt_cnt_r[1] <= '0;
        end else if (!filt_vld_r) begin
            filt_cnt_r[0] <= '0;
            filt_cnt_r[1] <= '0;
            if (sync_vld_s) begin
                filt_ab_r  <= sync_ab_s;
                filt_vld_r <= 1'b1;
            end
        end else begin
            for (int ch = 0; ch < 2; ch++) begin
                if (sync_ab_s[ch] == filt_ab_r[ch]) begin
                    filt_cnt_r[ch] <= '0;
                end else if (filt_cnt_r[ch] == FCNT_W'(FILTER_LEN - 1)) begin
                    filt_ab_r[ch]  <= sync_ab_s[ch];
                    filt_cnt_r[ch] <= '0;
                end else begin
                    filt_cnt_r[ch] <= filt_cnt_r[ch] + FCNT_W'(1);
                end
            end
        end
    end

    assign filt_ab_s  = filt_ab_r;
    assign filt_vld_s = filt_vld_r;
`else
    assign filt_ab_s  = sync_ab_s;
    assign filt_vld_s = sync_vld_s;
`endif

    // ------------------------------------------------------------------
    // Decoded state stage and transition decoder
    // ------------------------------------------------------------------
    logic [1:0]         cur_ab_r;
    logic               cur_vld_r;
    logic [1:0]         prev_ab_r;
    logic               prime_r;
    logic [COUNT_W-1:0] count_r;
    logic               updown_r;
    logic               step_r;
    logic               err_r;

    logic [1:0]         diff_s;
    logic [1:0]         prev_ab_nxt_s;
    logic               prime_nxt_s;
    logic [COUNT_W-1:0] count_nxt_s;
    logic               updown_nxt_s;
    logic               step_nxt_s;
    logic               err_nxt_s;

    // Register the (filtered) state so all decoding works on a stable value.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_ab_r  <= 2'b00;
            cur_vld_r <= 1'b0;
        end else begin
            cur_ab_r  <= filt_ab_s;
            cur_vld_r <= filt_vld_s;
        end
    end

    assign diff_s = ab_to_phase(cur_ab_r) - ab_to_phase(prev_ab_r);

    // Classify the transition and compute next count, direction, step and err.
    always_comb begin
        prev_ab_nxt_s = prev_ab_r;
        prime_nxt_s   = prime_r;
        count_nxt_s   = count_r;
        updown_nxt_s  = updown_r;
        step_nxt_s    = 1'b0;
        if (err_clr) begin
            err_nxt_s = 1'b0;
        end else begin
            err_nxt_s = err_r;
        end

        if (cur_vld_r && !prime_r) begin
            // First real state after reset only seeds the history.
            prev_ab_nxt_s = cur_ab_r;
            prime_nxt_s   = 1'b1;
        end else if (cur_vld_r) begin
            prev_ab_nxt_s = cur_ab_r;
            case (diff_s)
                2'd1: begin
                    if (enable) begin
                        count_nxt_s  = count_r + COUNT_W'(1);
                        updown_nxt_s = 1'b1;
                        step_nxt_s   = 1'b1;
                    end else begin
                        count_nxt_s  = count_r;
                    end
                end
                2'd3: begin
                    if (enable) begin
                        count_nxt_s  = count_r - COUNT_W'(1);
                        updown_nxt_s = 1'b0;
                        step_nxt_s   = 1'b1;
                    end else begin
                        count_nxt_s  = count_r;
                    end
                end
                2'd2: begin
                    // Both channels moved in one sample: direction unknown.
                    err_nxt_s = 1'b1;
                end
                default: begin
                    prev_ab_nxt_s = cur_ab_r;
                end
            endcase
        end else begin
            prev_ab_nxt_s = prev_ab_r;
        end
    end

    // Decoder state and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_ab_r <= 2'b00;
            prime_r   <= 1'b0;
            count_r   <= '0;
            updown_r  <= 1'b1;
            step_r    <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            prev_ab_r <= prev_ab_nxt_s;
            prime_r   <= prime_nxt_s;
            count_r   <= count_nxt_s;
            updown_r  <= updown_nxt_s;
            step_r    <= step_nxt_s;
            err_r     <= err_nxt_s;
        end
    end

    assign step   = step_r;
    assign upDown = updown_r;
    assign count  = count_r;
    assign err    = err_r;

endmodule

// File: tb/tb_quad_decoder.sv
// -----------------------------------------------------------------------------
// tb_quad_decoder
// Directed self-checking bench for quad_decoder (COUNT_W=32, SYNC_STAGES=2,
// FILTER_LEN=3). Build with QUAD_GLITCH_FILTER_EN defined to add the
// glitch-filter scenario and the longer expected latency.
// -----------------------------------------------------------------------------
module tb_quad_decoder;

    localparam int SYNC_STAGES = 2;
    localparam int FILTER_LEN  = 3;
`ifdef QUAD_GLITCH_FILTER_EN
    localparam int LAT = SYNC_STAGES + FILTER_LEN + 2;
`else
    localparam int LAT = SYNC_STAGES + 2;
`endif

    logic        clk;
    logic        reset;
    logic        enable;
    logic        chA;
    logic        chB;
    logic        err_clr;
    logic        step;
    logic        upDown;
    logic [31:0] count;
    logic        err;

    int n_checks;
    int n_errors;
    int step_cnt;
    int pos;

    quad_decoder #(
        .COUNT_W     (32),
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .chA     (chA),
        .chB     (chB),
        .err_clr (err_clr),
        .step    (step),
        .upDown  (upDown),
        .count   (count),
        .err     (err)
    );

    // 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count step pulses, sampled 2 time units after each rising edge.
    always @(posedge clk) begin
        #2;
        if (step === 1'b1) step_cnt++;
    end

    function automatic logic [1:0] phase_ab(input int p);
        logic [1:0] ab;
        case (p & 3)
            0:       ab = 2'b00;
            1:       ab = 2'b10;
            2:       ab = 2'b11;
            3:       ab = 2'b01;
            default: ab = 2'b00;
        endcase
        return ab;
    endfunction

    // Drive one phase step (dir = +1 up, -1 down) and hold for 10 clocks.
    task automatic move(input int dir);
        @(negedge clk);
        pos = (pos + dir) & 3;
        {chA, chB} = phase_ab(pos);
        repeat (9) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        pos = 0;
        {chA, chB} = 2'b00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (count !== 32'd0) begin n_errors++; $display("FAIL reset_count: got %h expected %h", count, 32'd0); end
        n_checks++; if (step !== 1'b0) begin n_errors++; $display("FAIL reset_step: got %b expected 0", step); end
        n_checks++; if (upDown !== 1'b1) begin n_errors++; $display("FAIL reset_updown: got %b expected 1", upDown); end
        n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL reset_err: got %b expected 0", err); end
        reset = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_up();
        step_cnt = 0;
        for (int i = 0; i < 16; i++) move(1);
        n_checks++; if (count !== 32'd16) begin n_errors++; $display("FAIL up_count: got %h expected %h", count, 32'd16); end
        n_checks++; if (upDown !== 1'b1) begin n_errors++; $display("FAIL up_dir: got %b expected 1", upDown); end
        n_checks++; if (step_cnt !== 16) begin n_errors++; $display("FAIL up_steps: got %0d expected 16", step_cnt); end
        n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL up_err: got %b expected 0", err); end
    endtask

    task automatic test_down_wrap();
        step_cnt = 0;
        for (int i = 0; i < 20; i++) move(-1);
        n_checks++; if (count !== 32'hFFFF_FFFC) begin n_errors++; $display("FAIL down_count: got %h expected %h", count, 32'hFFFF_FFFC); end
        n_checks++; if (upDown !== 1'b0) begin n_errors++; $display("FAIL down_dir: got %b expected 0", upDown); end
        n_checks++; if (step_cnt !== 20) begin n_errors++; $display("FAIL down_steps: got %0d expected 20", step_cnt); end
        n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL down_err: got %b expected 0", err); end
    endtask

    task automatic test_latency();
        int k;
        int found;
        found = 0;
        @(negedge clk);
        pos = (pos + 1) & 3;
        {chA, chB} = phase_ab(pos);
        for (k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (step === 1'b1 && found == 0) found = k;
        end
        repeat (2) @(negedge clk);
        n_checks++; if (found !== LAT) begin n_errors++; $display("FAIL latency: got %0d edges expected %0d", found, LAT); end
        n_checks++; if (count !== 32'hFFFF_FFFD) begin n_errors++; $display("FAIL latency_count: got %h expected %h", count, 32'hFFFF_FFFD); end
        n_checks++; if (upDown !== 1'b1) begin n_errors++; $display("FAIL latency_dir: got %b expected 1", upDown); end
    endtask

    task automatic test_enable();
        @(negedge clk);
        enable = 1'b0;
        step_cnt = 0;
        for (int i = 0; i < 8; i++) move(-1);
        n_checks++; if (step_cnt !== 0) begin n_errors++; $display("FAIL en0_steps: got %0d expected 0", step_cnt); end
        n_checks++; if (count !== 32'hFFFF_FFFD) begin n_errors++; $display("FAIL en0_count: got %h expected %h", count, 32'hFFFF_FFFD); end
        n_checks++; if (upDown !== 1'b1) begin n_errors++; $display("FAIL en0_dir: got %b expected 1", upDown); end
        enable = 1'b1;
        move(1);
        n_checks++; if (count !== 32'hFFFF_FFFE) begin n_errors++; $display("FAIL en1_count: got %h expected %h", count, 32'hFFFF_FFFE); end
        n_checks++; if (step_cnt !== 1) begin n_errors++; $display("FAIL en1_steps: got %0d expected 1", step_cnt); end
    endtask

    task automatic test_err();
        // Walk legally down to 00, then jump straight to 11.
        move(-1);
        move(-1);
        step_cnt = 0;
        @(negedge clk);
        pos = 2;
        {chA, chB} = 2'b11;
        repeat (9) @(negedge clk);
        n_checks++; if (err !== 1'b1) begin n_errors++; $display("FAIL err_set: got %b expected 1", err); end
        n_checks++; if (count !== 32'hFFFF_FFFC) begin n_errors++; $display("FAIL err_count: got %h expected %h", count, 32'hFFFF_FFFC); end
        n_checks++; if (step_cnt !== 0) begin n_errors++; $display("FAIL err_steps: got %0d expected 0", step_cnt); end
        n_checks++; if (upDown !== 1'b0) begin n_errors++; $display("FAIL err_dir: got %b expected 0", upDown); end
        // Clear alone.
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL err_clr: got %b expected 0", err); end
        // Move legally to 10, then 10 -> 01 with err_clr on the detecting edge.
        move(-1);
        @(negedge clk);
        pos = 3;
        {chA, chB} = 2'b01;
        repeat (LAT - 1) @(posedge clk);
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (err !== 1'b1) begin n_errors++; $display("FAIL err_clr_coincident: got %b expected 1", err); end
        n_checks++; if (count !== 32'hFFFF_FFFB) begin n_errors++; $display("FAIL err2_count: got %h expected %h", count, 32'hFFFF_FFFB); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 7; i++) move(1);
        move(-1);
        move(-1);
        n_checks++; if (count !== 32'd5) begin n_errors++; $display("FAIL mid_pre_count: got %h expected %h", count, 32'd5); end
        // Launch an up transition and reset while it is still in the synchronizer.
        @(negedge clk);
        pos = (pos + 1) & 3;
        {chA, chB} = phase_ab(pos);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_checks++; if (count !== 32'd0) begin n_errors++; $display("FAIL mid_rst_count: got %h expected %h", count, 32'd0); end
        n_checks++; if (upDown !== 1'b1) begin n_errors++; $display("FAIL mid_rst_dir: got %b expected 1", upDown); end
        reset = 1'b0;
        step_cnt = 0;
        repeat (10) @(negedge clk);
        n_checks++; if (count !== 32'd0) begin n_errors++; $display("FAIL mid_prime_count: got %h expected %h", count, 32'd0); end
        n_checks++; if (step_cnt !== 0) begin n_errors++; $display("FAIL mid_prime_steps: got %0d expected 0", step_cnt); end
        n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL mid_prime_err: got %b expected 0", err); end
        move(1);
        n_checks++; if (count !== 32'd1) begin n_errors++; $display("FAIL mid_post_count: got %h expected %h", count, 32'd1); end
        n_checks++; if (step_cnt !== 1) begin n_errors++; $display("FAIL mid_post_steps: got %0d expected 1", step_cnt); end
    endtask

`ifdef QUAD_GLITCH_FILTER_EN
    task automatic test_filter();
        int k;
        int found;
        // pos is 3 (01); a 2-cycle pulse on A must be ignored.
        step_cnt = 0;
        @(negedge clk);
        chA = 1'b1;
        repeat (2) @(negedge clk);
        chA = 1'b0;
        repeat (12) @(negedge clk);
        n_checks++; if (step_cnt !== 0) begin n_errors++; $display("FAIL filt_pulse_steps: got %0d expected 0", step_cnt); end
        n_checks++; if (count !== 32'd1) begin n_errors++; $display("FAIL filt_pulse_count: got %h expected %h", count, 32'd1); end
        // Stable change 01 -> 11 (down) is accepted once.
        found = 0;
        pos = 2;
        chA = 1'b1;
        for (k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (step === 1'b1 && found == 0) found = k;
        end
        repeat (2) @(negedge clk);
        n_checks++; if (found !== LAT) begin n_errors++; $display("FAIL filt_latency: got %0d edges expected %0d", found, LAT); end
        n_checks++; if (step_cnt !== 1) begin n_errors++; $display("FAIL filt_steps: got %0d expected 1", step_cnt); end
        n_checks++; if (count !== 32'd0) begin n_errors++; $display("FAIL filt_count: got %h expected %h", count, 32'd0); end
    endtask
`endif

    initial begin
        n_checks = 0;
        n_errors = 0;
        step_cnt = 0;
        pos      = 0;
        reset    = 1'b1;
        enable   = 1'b1;
        chA      = 1'b0;
        chB      = 1'b0;
        err_clr  = 1'b0;

        test_reset();
        test_up();
        test_down_wrap();
        test_latency();
        test_enable();
        test_err();
        test_reset_mid();
`ifdef QUAD_GLITCH_FILTER_EN
        test_filter();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
